// File: rtl/dct_pair_scheduler.sv
// Two-point DCT pair scheduler: captures pixel pairs (A,B) and emits truncated
// sum and difference coefficients with valid/ready handshakes and block framing.
module dct_pair_scheduler #(
  parameter int BLOCK_PAIRS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [1:0] trunc_bits,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_coef,
  output logic       out_sel,
  output logic       out_last,
  output logic       block_done
);

  localparam logic [1:0] GET_A     = 2'd0;
  localparam logic [1:0] GET_B     = 2'd1;
  localparam logic [1:0] EMIT_SUM  = 2'd2;
  localparam logic [1:0] EMIT_DIFF = 2'd3;
  localparam logic [4:0] LAST_PAIR = 5'(BLOCK_PAIRS - 1);

  function automatic logic [7:0] trunc_coef(input logic [7:0] v, input logic [1:0] t);
    logic [7:0] r;
    case (t)
      2'd0:    r = v;
      2'd1:    r = {v[7:1], 1'b0};
      2'd2:    r = {v[7:2], 2'b00};
      2'd3:    r = {v[7:3], 3'b000};
      default: r = v;
    endcase
    return r;
  endfunction

  logic [1:0] state_r, state_nxt_s;
  logic [7:0] a_r, a_nxt_s;
  logic [1:0] trunc_r, trunc_nxt_s;
  logic [7:0] sum_r, sum_nxt_s;
  logic [7:0] diff_r, diff_nxt_s;
  logic [4:0] pair_cnt_r, cnt_nxt_s;
  logic       done_nxt_s;
  logic [7:0] coef_nxt_s;
  logic       in_ready_r, out_valid_r, out_sel_r, out_last_r, block_done_r;
  logic [7:0] out_coef_r;
  logic       in_hs_s, out_hs_s;
  logic [7:0] sum_raw_s, diff_raw_s;

  assign in_hs_s    = in_valid & in_ready_r;
  assign out_hs_s   = out_valid_r & out_ready;
  assign sum_raw_s  = a_r + in_pixel;
  assign diff_raw_s = a_r - in_pixel;

  // Next-state, datapath capture and next-output computation
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    trunc_nxt_s = trunc_r;
    sum_nxt_s   = sum_r;
    diff_nxt_s  = diff_r;
    cnt_nxt_s   = pair_cnt_r;
    done_nxt_s  = 1'b0;
    coef_nxt_s  = 8'd0;
    // restart voids any handshake happening in the same cycle
    if (restart) begin
      state_nxt_s = GET_A;
      a_nxt_s     = 8'd0;
      sum_nxt_s   = 8'd0;
      diff_nxt_s  = 8'd0;
      cnt_nxt_s   = 5'd0;
    end else begin
      case (state_r)
        GET_A: begin
          if (in_hs_s) begin
            a_nxt_s     = in_pixel;
            trunc_nxt_s = trunc_bits;
            state_nxt_s = GET_B;
          end else begin
            state_nxt_s = GET_A;
          end
        end
        GET_B: begin
          if (in_hs_s) begin
            sum_nxt_s   = trunc_coef(sum_raw_s, trunc_r);
            diff_nxt_s  = trunc_coef(diff_raw_s, trunc_r);
            state_nxt_s = EMIT_SUM;
          end else begin
            state_nxt_s = GET_B;
          end
        end
        EMIT_SUM: begin
          if (out_hs_s) begin
            state_nxt_s = EMIT_DIFF;
          end else begin
            state_nxt_s = EMIT_SUM;
          end
        end
        EMIT_DIFF: begin
          if (out_hs_s) begin
            state_nxt_s = GET_A;
            done_nxt_s  = (pair_cnt_r == LAST_PAIR);
            cnt_nxt_s   = (pair_cnt_r == LAST_PAIR) ? 5'd0 : pair_cnt_r + 5'd1;
          end else begin
            state_nxt_s = EMIT_DIFF;
          end
        end
        default: state_nxt_s = GET_A;
      endcase
    end
    case (state_nxt_s)
      EMIT_SUM:  coef_nxt_s = sum_nxt_s;
      EMIT_DIFF: coef_nxt_s = diff_nxt_s;
      default:   coef_nxt_s = 8'd0;
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= GET_A;
      a_r          <= 8'd0;
      trunc_r      <= 2'd0;
      sum_r        <= 8'd0;
      diff_r       <= 8'd0;
      pair_cnt_r   <= 5'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_coef_r   <= 8'd0;
      out_sel_r    <= 1'b0;
      out_last_r   <= 1'b0;
      block_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      a_r          <= a_nxt_s;
      trunc_r      <= trunc_nxt_s;
      sum_r        <= sum_nxt_s;
      diff_r       <= diff_nxt_s;
      pair_cnt_r   <= cnt_nxt_s;
      in_ready_r   <= (state_nxt_s == GET_A) || (state_nxt_s == GET_B);
      out_valid_r  <= (state_nxt_s == EMIT_SUM) || (state_nxt_s == EMIT_DIFF);
      out_coef_r   <= coef_nxt_s;
      out_sel_r    <= (state_nxt_s == EMIT_DIFF);
      out_last_r   <= (state_nxt_s == EMIT_DIFF) && (cnt_nxt_s == LAST_PAIR);
      block_done_r <= done_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_coef   = out_coef_r;
  assign out_sel    = out_sel_r;
  assign out_last   = out_last_r;
  assign block_done = block_done_r;

endmodule

// File: tb/tb_dct_pair_scheduler.sv
// Self-checking bench for dct_pair_scheduler: directed corner cases plus random
// pairs checked against an arithmetic pair/block model.
module tb_dct_pair_scheduler;

  localparam int BP = 4;

  logic       clk;
  logic       rst;
  logic       restart;
  logic [1:0] trunc_bits;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_coef;
  logic       out_sel;
  logic       out_last;
  logic       block_done;

  int errors   = 0;
  int checks   = 0;
  int pair_idx = 0;

  dct_pair_scheduler #(.BLOCK_PAIRS(BP)) dut (
    .clk(clk), .rst(rst), .restart(restart), .trunc_bits(trunc_bits),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_sel(out_sel), .out_last(out_last), .block_done(block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: coefficient with the low t bits cleared
  function automatic logic [7:0] tmask(input logic [7:0] v, input logic [1:0] t);
    return (v >> t) << t;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
  endtask

  // One full pair: starts and ends on a falling edge with the DUT in GET_A
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic [1:0] tb,
                           input int gap_b, input int st_sum, input int st_diff);
    logic [7:0] es, ed;
    logic       el;
    es = tmask(a + b, tb);
    ed = tmask(a - b, tb);
    el = (pair_idx == BP - 1);
    chk_idle("get_a");
    in_valid = 1'b1; in_pixel = a; trunc_bits = tb;
    @(negedge clk);
    in_valid = 1'b0; trunc_bits = 2'($urandom);
    for (int i = 0; i < gap_b; i++) begin
      chk_idle("hold_a");
      @(negedge clk);
    end
    chk_idle("get_b");
    in_valid = 1'b1; in_pixel = b;
    @(negedge clk);
    in_pixel = 8'($urandom);
    for (int i = 0; i <= st_sum; i++) begin
      out_ready = (i == st_sum);
      chk1("sum_valid", out_valid, 1'b1);
      chk8("sum_coef", out_coef, es);
      chk1("sum_sel", out_sel, 1'b0);
      chk1("sum_last", out_last, 1'b0);
      chk1("sum_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i <= st_diff; i++) begin
      out_ready = (i == st_diff);
      chk1("diff_valid", out_valid, 1'b1);
      chk8("diff_coef", out_coef, ed);
      chk1("diff_sel", out_sel, 1'b1);
      chk1("diff_last", out_last, el);
      chk1("diff_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk1("block_done", block_done, el);
    pair_idx = (pair_idx + 1) % BP;
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; trunc_bits = 2'd0; in_valid = 1'b0;
    in_pixel = 8'd0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_out_coef", out_coef, 8'h00);
    chk1("rst_out_sel", out_sel, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_block_done", block_done, 1'b0);

    // Known-answer pairs, hold of A, stalls, and a full block boundary
    send_pair(8'd10, 8'd3, 2'd2, 0, 0, 0);
    send_pair(8'd100, 8'd100, 2'd0, 0, 0, 0);
    send_pair(8'h80, 8'h01, 2'd2, 2, 3, 1);
    send_pair(8'h7F, 8'h7F, 2'd1, 0, 0, 2);
    send_pair(8'hFF, 8'h01, 2'd3, 0, 0, 0);

    // restart in GET_B with a pixel offered: that pixel is dropped
    chk_idle("rs_get_a");
    in_valid = 1'b1; in_pixel = 8'd55; trunc_bits = 2'd0;
    @(negedge clk);
    in_pixel = 8'd77; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; in_valid = 1'b0;
    chk_idle("rs_after");
    chk1("rs_block_done", block_done, 1'b0);
    pair_idx = 0;
    for (int i = 0; i < BP; i++)
      send_pair(8'($urandom), 8'($urandom), 2'($urandom), 0, 0, 0);

    // restart while sum is offered and accepted: handshake is void
    in_valid = 1'b1; in_pixel = 8'd20;
    @(negedge clk);
    in_pixel = 8'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("rs2_sum_valid", out_valid, 1'b1);
    restart = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    restart = 1'b0; out_ready = 1'b0;
    chk_idle("rs2_after");
    pair_idx = 0;

    // rst during EMIT_DIFF of the last pair of a block
    for (int i = 0; i < BP - 1; i++)
      send_pair(8'($urandom), 8'($urandom), 2'($urandom), 0, 0, 0);
    in_valid = 1'b1; in_pixel = 8'd9;
    @(negedge clk);
    in_pixel = 8'd2;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    chk1("pre_rst_diff_sel", out_sel, 1'b1);
    chk1("pre_rst_diff_last", out_last, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    chk_idle("rst_mid");
    chk1("rst_mid_block_done", block_done, 1'b0);
    chk1("rst_mid_out_last", out_last, 1'b0);
    pair_idx = 0;

    // Random pairs with random gaps and stalls
    for (int i = 0; i < 40; i++)
      send_pair(8'($urandom), 8'($urandom), 2'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
